// File: rtl/des_round_key_seq.sv
`default_nettype none
//==============================================================================
// Module      : des_round_key_seq
// Description : Sequential DES key scheduler. Produces one 48-bit round key
//               per handshake for an iterative DES round datapath.
//               Encrypt mode emits K1..K16 by rotating C/D left. Decrypt mode
//               emits K16..K1 by rotating C/D right, so no key table is kept.
//
// Ports
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   synchronous active-low reset
//   start      in   1   start request, sampled only while idle
//   decrypt    in   1   mode, sampled with start (0: K1..K16, 1: K16..K1)
//   key        in  64   DES key, DES bit n = key[64-n]; parity in key[8k]
//   busy       out  1   high from the accepted start until done
//   rk_valid   out  1   round_key / round_idx valid
//   rk_ready   in   1   consumer accepts the current round key
//   round_key  out 48   PC-2 output, DES bit 1 = round_key[47]; 0 when idle
//   round_idx  out  4   output ordinal 0..15 (not the DES round number)
//   done       out  1   one-cycle pulse after the 16th handshake
//   par_err    out  1   one-cycle pulse when a key fails odd parity
//
// Revision    : 1.0 - initial release
//==============================================================================
module des_round_key_seq #(
    parameter bit PARITY_CHK = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic        busy,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [47:0] round_key,
    output logic [3:0]  round_idx,
    output logic        done,
    output logic        par_err
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_EMIT = 1'b1;

    // -------------------------------------------------------------------------
    // Permuted choice tables, in DES bit numbering (bit 1 = MSB).
    // PC-1 selects from the 64-bit key; the first 28 entries form C, the
    // last 28 form D. PC-2 selects from the 56-bit {C, D} concatenation.
    // -------------------------------------------------------------------------
    localparam int c_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int c_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // PC-1: returns {C, D}; DES bit 57 (key[7]) lands in C[27].
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] cd;
        cd = '0;
        for (logic [5:0] i = 6'd0; i < 6'd56; i = i + 6'd1) begin
            cd[6'd55 - i] = k[6'(64 - c_PC1[i])];
        end
        return cd;
    endfunction

    // PC-2 over {C, D}; {C, D} bit n (DES numbering) is cd[56-n].
    function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
        logic [55:0] cd;
        logic [47:0] k;
        cd = {c, d};
        k  = '0;
        for (logic [5:0] i = 6'd0; i < 6'd48; i = i + 6'd1) begin
            k[6'd47 - i] = cd[6'(56 - c_PC2[i])];
        end
        return k;
    endfunction

    // Rounds 1, 2, 9 and 16 shift by one position, all others by two.
    function automatic logic shift_is_one(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16);
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic        r_dec;
    logic [3:0]  r_idx;
    logic        r_busy;
    logic        r_valid;
    logic        r_done;
    logic        r_par_err;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic [7:0]  w_byte_odd;
    logic        w_key_ok;
    logic [55:0] w_pc1_cd;
    logic [27:0] w_pc1_c;
    logic [27:0] w_pc1_d;
    logic        w_step_one;
    logic [27:0] w_next_c;
    logic [27:0] w_next_d;
    logic [47:0] w_subkey;
    logic        w_handshake;

    // Each key byte must carry an odd number of ones.
    for (genvar b = 0; b < 8; b++) begin : g_parity
        assign w_byte_odd[b] = ^key[8*b+7 : 8*b];
    end

    assign w_key_ok    = PARITY_CHK ? (&w_byte_odd) : 1'b1;
    assign w_handshake = r_valid & rk_ready;

    always_comb begin
        w_pc1_cd = pc1(key);
        w_pc1_c  = w_pc1_cd[55:28];
        w_pc1_d  = w_pc1_cd[27:0];

        // Encrypt moves from round idx+1 to idx+2, decrypt from 16-idx back
        // to 15-idx, so the shift undone is that of round 16-idx.
        if (r_dec) begin
            w_step_one = shift_is_one(5'd16 - {1'b0, r_idx});
        end else begin
            w_step_one = shift_is_one({1'b0, r_idx} + 5'd2);
        end

        if (r_dec) begin
            w_next_c = ror28(r_c, w_step_one);
            w_next_d = ror28(r_d, w_step_one);
        end else begin
            w_next_c = rol28(r_c, w_step_one);
            w_next_d = rol28(r_d, w_step_one);
        end

        w_subkey = pc2(r_c, r_d);
    end

    // -------------------------------------------------------------------------
    // Control FSM and C/D rotation
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_c       <= '0;
            r_d       <= '0;
            r_dec     <= 1'b0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_par_err <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        if (w_key_ok) begin
                            r_dec   <= decrypt;
                            r_busy  <= 1'b1;
                            r_valid <= 1'b1;
                            r_idx   <= '0;
                            r_state <= c_ST_EMIT;
                            // Decrypt starts at K16, whose C/D equal PC-1
                            // (total rotation of 28); encrypt starts at K1.
                            if (decrypt) begin
                                r_c <= w_pc1_c;
                                r_d <= w_pc1_d;
                            end else begin
                                r_c <= rol28(w_pc1_c, 1'b1);
                                r_d <= rol28(w_pc1_d, 1'b1);
                            end
                        end else begin
                            r_par_err <= 1'b1;
                        end
                    end
                end

                c_ST_EMIT: begin
                    if (w_handshake) begin
                        if (r_idx == 4'd15) begin
                            r_state <= c_ST_IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_idx   <= '0;
                            // Encrypt has already rotated 28 positions; decrypt
                            // still owes round 1's right shift to get back to PC-1.
                            if (r_dec) begin
                                r_c <= w_next_c;
                                r_d <= w_next_d;
                            end
                        end else begin
                            r_idx <= r_idx + 4'd1;
                            r_c   <= w_next_c;
                            r_d   <= w_next_d;
                        end
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy      = r_busy;
    assign rk_valid  = r_valid;
    assign round_key = r_valid ? w_subkey : '0;
    assign round_idx = r_idx;
    assign done      = r_done;
    assign par_err   = r_par_err;

endmodule
`default_nettype wire

// File: doc/des_round_key_seq.md
Name: des_round_key_seq

Overview:
- Sequential DES key scheduler; feeds the iterative round datapath one 48-bit subkey per round.
- Encrypt mode emits K1..K16. Decrypt mode emits K16..K1 by rotating C/D right (inverse schedule). No 16-entry key table.
- Valid/ready output handshake; the consumer can stall between rounds.

Parameters:
- PARITY_CHK, 0: when 1, check odd parity of each key byte at start; a bad key is rejected.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  start request; sampled only in IDLE
- decrypt  input  1  mode, sampled with start: 0 = K1..K16, 1 = K16..K1
- key  input  64  DES key; DES bit n = key[64-n]; parity bits key[0],key[8],..,key[56]
- busy  output  1  high from the accepted start until done
- rk_valid  output  1  round_key/round_idx valid
- rk_ready  input  1  consumer accepts the current key
- round_key  output  48  PC-2 output; DES bit 1 = round_key[47]
- round_idx  output  4  output ordinal 0..15 (not the DES round number)
- done  output  1  one-cycle pulse after the 16th handshake
- par_err  output  1  one-cycle pulse when a key is rejected (PARITY_CHK=1 only)

Behaviour:
- Reset: the cycle after rst_n=0 at a clock edge, all outputs are 0, state is IDLE, C/D are 0. Reset during an operation aborts it; no done pulse is generated.
- States are IDLE and EMIT.
- Key schedule definitions:
  - C/D are two 28-bit registers loaded from PC-1(key), standard table. The first PC-1 bit (DES bit 57 = key[7]) is C[27].
  - Shift amount s(r) is 1 for r in {1,2,9,16}, else 2.
- IDLE, start=1 with PARITY_CHK=0, or with all key bytes odd parity:
  - Latch the mode and set busy=1.
  - Load C/D as PC-1(key) rotated:
    - encrypt: rotate left s(1)=1.
    - decrypt: no rotation, giving K16.
  - round_idx=0; go to EMIT.
  - rk_valid=1 the following cycle, so latency from start to the first key is 1 clock.
- IDLE, start=1 with a parity failure:
  - par_err=1 for one cycle; stay IDLE; busy stays 0; C/D are unchanged.
- EMIT:
  - round_key = PC-2(C,D), combinational from the registers.
  - rk_valid=1 continuously.
  - round_key and round_idx are held stable while rk_ready=0.
- Handshake (rk_valid & rk_ready) with round_idx<15:
  - Increment round_idx and apply the next rotation:
    - encrypt: rotate left s(round_idx+2).
    - decrypt: rotate right s(16-round_idx).
  - The next key is valid the next cycle, so with rk_ready held high there is one key per clock.
- Handshake with round_idx=15:
  - Next cycle: done=1 for one cycle, rk_valid=0, busy=0, state IDLE.
  - After the full sequence, C/D equal the PC-1 value (total rotation 28).
- round_key is forced to 0 whenever rk_valid=0.
- start while busy is ignored. start in the same cycle as the done pulse is accepted, since the state is IDLE then.
- key and decrypt are ignored after the start cycle.
- C and D rotate independently; wrap is within 28 bits.

Test Plan:
- Encrypt:
  - Stimulus: key=64'h133457799BBCDFF1, decrypt=0, rk_ready=1.
  - Response: the cycle after start, round_key=48'h1B02EFFC7072 with idx 0; next cycle 48'h79AED9DBC9E5; idx 15 = 48'hCB3D8B0E17F5; done pulses the cycle after idx 15; 16 consecutive valid cycles.
- Decrypt:
  - Stimulus: same key, decrypt=1.
  - Response: idx 0 = 48'hCB3D8B0E17F5; idx 15 = 48'h1B02EFFC7072; the sequence is exactly the reverse of the encrypt run.
- Backpressure:
  - Stimulus: encrypt run with rk_ready low for 3 cycles at idx 1.
  - Response: round_key stays 48'h79AED9DBC9E5 and idx stays 1 throughout; the sequence is unchanged; done arrives 3 cycles later than in the unstalled run.
- Start while busy, and reset:
  - Stimulus: start pulse with decrypt=1 at idx 5 of an encrypt run.
  - Response: ignored; encrypt keys continue.
  - Stimulus: rst_n=0 at idx 8.
  - Response: the next cycle all outputs are 0 and no done pulse occurs; a new start afterwards yields 48'h1B02EFFC7072 first.
- Parity (PARITY_CHK=1):
  - Stimulus: key=64'h133457799BBCDFF0.
  - Response: par_err pulses for one cycle; busy and rk_valid stay 0.
  - Stimulus: key=64'h133457799BBCDFF1.
  - Response: normal run.
- Back-to-back:
  - Stimulus: start asserted in the done cycle with decrypt=1.
  - Response: the next cycle is rk_valid with 48'hCB3D8B0E17F5.
